// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate-unit BIST controller.
// Holds the FSM state enum, gate_y bit indices and NUM_GATES.
package gate_bist_pkg;

  localparam int NUM_GATES = 7;

  localparam int IDX_AND  = 0;
  localparam int IDX_NAND = 1;
  localparam int IDX_OR   = 2;
  localparam int IDX_NOR  = 3;
  localparam int IDX_NOT  = 4;
  localparam int IDX_XOR  = 5;
  localparam int IDX_XNOR = 6;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

endpackage

// File: rtl/gate_bist_if.sv
// Bundle between the BIST controller and its tester / gate unit.
// slave: controller side; master: stimulus / gate-unit side.
// GATE_BIST_ERRLOG_EN adds first_fail_valid / first_fail_idx.
interface gate_bist_if;
  import gate_bist_pkg::*;

  logic                 start;
  logic                 gate_a;
  logic                 gate_b;
  logic [NUM_GATES-1:0] gate_y;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [NUM_GATES-1:0] fail_vec;
`ifdef GATE_BIST_ERRLOG_EN
  logic                 first_fail_valid;
  logic [1:0]           first_fail_idx;

  modport slave (
    input  start, gate_y,
    output gate_a, gate_b, busy, done,
    output pass, fail_vec,
    output first_fail_valid, first_fail_idx
  );
  modport master (
    output start, gate_y,
    input  gate_a, gate_b, busy, done,
    input  pass, fail_vec,
    input  first_fail_valid, first_fail_idx
  );
`else
  modport slave (
    input  start, gate_y,
    output gate_a, gate_b, busy, done,
    output pass, fail_vec
  );
  modport master (
    output start, gate_y,
    input  gate_a, gate_b, busy, done,
    input  pass, fail_vec
  );
`endif

endinterface

// File: rtl/gate_golden.sv
// Combinational reference truth table of the seven-gate unit.
// Ports: i_a, i_b in; o_y expected results (gate_y bit order).
module gate_golden
  import gate_bist_pkg::*;
(
  input  logic                 i_a,
  input  logic                 i_b,
  output logic [NUM_GATES-1:0] o_y
);

  always_comb begin
    o_y           = '0;
    o_y[IDX_AND]  = i_a & i_b;
    o_y[IDX_NAND] = ~(i_a & i_b);
    o_y[IDX_OR]   = i_a | i_b;
    o_y[IDX_NOR]  = ~(i_a | i_b);
    o_y[IDX_NOT]  = ~i_a;
    o_y[IDX_XOR]  = i_a ^ i_b;
    o_y[IDX_XNOR] = ~(i_a ^ i_b);
  end

endmodule

// File: rtl/gate_bist_ctrl.sv
// Truth-table sweep BIST for a seven-gate logic unit.
// Ports: clk, rst_n (async low), bus (gate_bist_if.slave):
//   start in, gate_a/gate_b out, gate_y in, busy/done/pass/
//   fail_vec out. Optional GATE_BIST_ERRLOG_EN adds
//   first_fail_valid / first_fail_idx.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int SETTLE_CYC = 2
) (
  input logic     clk,
  input logic     rst_n,
  gate_bist_if.slave bus
);

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_vec;
  logic [3:0]           r_cnt;
  logic [NUM_GATES-1:0] r_fail;
  logic                 r_pass;
  logic [NUM_GATES-1:0] w_exp;
  logic [NUM_GATES-1:0] w_diff;
  logic                 w_cnt_end;
  logic                 w_last;

  gate_golden u_golden (
    .i_a (r_vec[1]),
    .i_b (r_vec[0]),
    .o_y (w_exp)
  );

  assign w_diff    = bus.gate_y ^ w_exp;
  assign w_cnt_end = (r_cnt == 4'(SETTLE_CYC - 1));
  assign w_last    = (r_vec == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   if (bus.start) w_next = SETTLE;
      SETTLE: if (w_cnt_end) w_next = SAMPLE;
      SAMPLE: w_next = w_last ? DONE : SETTLE;
      DONE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec  <= '0;
      r_cnt  <= '0;
      r_fail <= '0;
      r_pass <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_vec  <= '0;
            r_cnt  <= '0;
            r_fail <= '0;
            r_pass <= 1'b0;
          end
        end
        SETTLE: begin
          r_cnt <= w_cnt_end ? 4'd0 : r_cnt + 4'd1;
        end
        SAMPLE: begin
          r_fail <= r_fail | w_diff;
          // pass must already be valid in the DONE cycle
          if (w_last)
            r_pass <= ((r_fail | w_diff) == '0);
          else
            r_vec <= r_vec + 2'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef GATE_BIST_ERRLOG_EN
  logic       r_ff_valid;
  logic [1:0] r_ff_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ff_valid <= 1'b0;
      r_ff_idx   <= '0;
    end else if (r_state == IDLE && bus.start) begin
      r_ff_valid <= 1'b0;
      r_ff_idx   <= '0;
    end else if (r_state == SAMPLE &&
                 |w_diff && !r_ff_valid) begin
      r_ff_valid <= 1'b1;
      r_ff_idx   <= r_vec;
    end
  end

  assign bus.first_fail_valid = r_ff_valid;
  assign bus.first_fail_idx   = r_ff_idx;
`endif

  // Decoded from state so async reset clears them at once
  always_comb begin
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    bus.gate_a = 1'b0;
    bus.gate_b = 1'b0;
    unique case (1'b1)
      (r_state == SETTLE),
      (r_state == SAMPLE): begin
        bus.busy   = 1'b1;
        bus.gate_a = r_vec[1];
        bus.gate_b = r_vec[0];
      end
      (r_state == DONE): bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.pass     = r_pass;
  assign bus.fail_vec = r_fail;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Self-checking bench for gate_bist_ctrl (SETTLE_CYC 2 and 1).
// Gate unit model with per-vector flip masks and stuck-at-0 bits.
module tb_gate_bist_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic st0 = 1'b0;
  logic st1 = 1'b0;
  logic sel = 1'b0;
  logic [6:0] fm [4];
  logic [6:0] stuck0 = '0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gate_bist_if if0 ();
  gate_bist_if if1 ();

  gate_bist_ctrl #(.SETTLE_CYC(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  gate_bist_ctrl #(.SETTLE_CYC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  function automatic logic [6:0] truth(input int v);
    logic a, b;
    a = v[1];
    b = v[0];
    return {~(a ^ b), a ^ b, ~a, ~(a | b),
            a | b, ~(a & b), a & b};
  endfunction

  function automatic logic [6:0] unit_y(input int v);
    return (truth(v) & ~stuck0) ^ fm[v];
  endfunction

  assign if0.start = st0;
  assign if1.start = st1;
  always_comb if0.gate_y =
    (truth({if0.gate_a, if0.gate_b}) & ~stuck0)
    ^ fm[{if0.gate_a, if0.gate_b}];
  always_comb if1.gate_y =
    (truth({if1.gate_a, if1.gate_b}) & ~stuck0)
    ^ fm[{if1.gate_a, if1.gate_b}];

  logic m_a, m_b, m_busy, m_done, m_pass;
  logic [6:0] m_fail;
  always_comb begin
    if (sel) begin
      m_a = if1.gate_a; m_b = if1.gate_b;
      m_busy = if1.busy; m_done = if1.done;
      m_pass = if1.pass; m_fail = if1.fail_vec;
    end else begin
      m_a = if0.gate_a; m_b = if0.gate_b;
      m_busy = if0.busy; m_done = if0.done;
      m_pass = if0.pass; m_fail = if0.fail_vec;
    end
  end
`ifdef GATE_BIST_ERRLOG_EN
  logic m_ffv;
  logic [1:0] m_ffi;
  assign m_ffv = sel ? if1.first_fail_valid
                     : if0.first_fail_valid;
  assign m_ffi = sel ? if1.first_fail_idx
                     : if0.first_fail_idx;
`endif

  task automatic drive_start(input logic v);
    if (sel) st1 = v;
    else     st0 = v;
  endtask

  task automatic clear_unit();
    for (int k = 0; k < 4; k++) fm[k] = '0;
    stuck0 = '0;
  endtask

  // One sweep, checked every cycle against the timing model:
  // vector v occupies cycles v*(s+1)+1 .. v*(s+1)+s+1,
  // the last of which samples; done at 4*(s+1)+1.
  task automatic run_sweep(input int s, input bit extra,
                           input string nm);
    int lat, ndone, v, ph;
    bit insw;
    logic ea, eb, ep, efv;
    logic [1:0] eidx;
    logic [6:0] acc, d, ef;
    ef = '0;
    for (int k = 0; k < 4; k++) ef |= unit_y(k) ^ truth(k);
    lat = 4 * (s + 1) + 1;
    acc = '0; efv = 1'b0; eidx = '0; ndone = 0;
    drive_start(1'b1);
    @(posedge clk); #1;
    drive_start(1'b0);
    for (int c = 1; c <= lat + 3; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      drive_start(extra && (c == 4 || c == lat));
      insw = (c <= 4 * (s + 1));
      v = (c - 1) / (s + 1);
      ph = (c - 1) % (s + 1);
      ea = insw ? v[1] : 1'b0;
      eb = insw ? v[0] : 1'b0;
      ep = (c >= lat) ? (ef == '0) : 1'b0;
      if (m_done) ndone++;
      n_cmp += 6;
      if (m_a !== ea) begin n_err++;
        $display("FAIL %s c%0d gate_a got %b exp %b",
                 nm, c, m_a, ea); end
      if (m_b !== eb) begin n_err++;
        $display("FAIL %s c%0d gate_b got %b exp %b",
                 nm, c, m_b, eb); end
      if (m_busy !== insw) begin n_err++;
        $display("FAIL %s c%0d busy got %b exp %b",
                 nm, c, m_busy, insw); end
      if (m_done !== (c == lat)) begin n_err++;
        $display("FAIL %s c%0d done got %b exp %b",
                 nm, c, m_done, (c == lat)); end
      if (m_pass !== ep) begin n_err++;
        $display("FAIL %s c%0d pass got %b exp %b",
                 nm, c, m_pass, ep); end
      if (m_fail !== acc) begin n_err++;
        $display("FAIL %s c%0d fail_vec got %b exp %b",
                 nm, c, m_fail, acc); end
`ifdef GATE_BIST_ERRLOG_EN
      n_cmp += 2;
      if (m_ffv !== efv) begin n_err++;
        $display("FAIL %s c%0d ff_valid got %b exp %b",
                 nm, c, m_ffv, efv); end
      if (m_ffi !== eidx) begin n_err++;
        $display("FAIL %s c%0d ff_idx got %0d exp %0d",
                 nm, c, m_ffi, eidx); end
`endif
      if (insw && ph == s) begin
        d = unit_y(v) ^ truth(v);
        acc |= d;
        if (d != '0 && !efv) begin
          efv = 1'b1;
          eidx = 2'(v);
        end
      end
    end
    drive_start(1'b0);
    n_cmp++;
    if (ndone != 1) begin n_err++;
      $display("FAIL %s done_count got %0d exp 1",
               nm, ndone); end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({if0.gate_a, if0.gate_b, if0.busy, if0.done,
         if0.pass, if0.fail_vec} !== 11'd0) begin n_err++;
      $display("FAIL reset outputs got %b exp 0",
        {if0.gate_a, if0.gate_b, if0.busy, if0.done,
         if0.pass, if0.fail_vec}); end
  endtask

  task automatic test_correct();
    clear_unit();
    run_sweep(2, 1'b0, "correct");
  endtask

  task automatic test_xor_stuck();
    clear_unit();
    stuck0[5] = 1'b1;
    run_sweep(2, 1'b0, "xor_sa0");
    n_cmp++;
    if (if0.fail_vec !== 7'b0100000) begin n_err++;
      $display("FAIL xor_sa0 final fail_vec got %b exp %b",
               if0.fail_vec, 7'b0100000); end
  endtask

  task automatic test_ignored_start();
    clear_unit();
    run_sweep(2, 1'b1, "ignored_start");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++)
        fm[k] = ($urandom_range(0, 2) == 0)
                ? 7'($urandom) : 7'd0;
      stuck0 = ($urandom_range(0, 3) == 0)
               ? 7'($urandom) : 7'd0;
      run_sweep(2, 1'($urandom), "random");
    end
  endtask

  task automatic test_reset_mid();
    clear_unit();
    fm[0] = 7'b0000001;
    st0 = 1'b1;
    @(posedge clk); #1;
    st0 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({if0.gate_a, if0.gate_b, if0.busy, if0.done,
         if0.pass, if0.fail_vec} !== 11'd0) begin n_err++;
      $display("FAIL reset_mid async got %b exp 0",
        {if0.gate_a, if0.gate_b, if0.busy, if0.done,
         if0.pass, if0.fail_vec}); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (if0.done !== 1'b0 || if0.busy !== 1'b0) begin
        n_err++;
        $display("FAIL reset_mid resume c%0d done %b busy %b exp 0 0",
                 c, if0.done, if0.busy); end
    end
    clear_unit();
    run_sweep(2, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    clear_unit();
    fm[2] = 7'b0011000;
    run_sweep(2, 1'b0, "b2b_fail");
    clear_unit();
    run_sweep(2, 1'b0, "b2b_fixed");
  endtask

  task automatic test_settle1();
    clear_unit();
    sel = 1'b1;
    run_sweep(1, 1'b0, "settle1");
    fm[3] = 7'b1000000;
    run_sweep(1, 1'b0, "settle1_fail");
    sel = 1'b0;
  endtask

  initial begin
    clear_unit();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_correct();
    test_xor_stuck();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    test_settle1();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
